// File: rtl/storage_arbiter_pkg.sv
// Shared constants and types for the storage RAM arbiter.
package storage_arbiter_pkg;

  localparam int REQ_INPUT = 0;
  localparam int REQ_DISP  = 1;
  localparam int REQ_CALC  = 2;
  localparam int NUM_REQ   = 3;

  localparam logic [1:0] OWNER_NONE = 2'd3;

  // ARB: no owner, round-robin among valid requesters.
  // LOCKED: a single owner holds the RAM until it releases or the watchdog fires.
  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Fold an index in 0..2*NUM_REQ-1 back into 0..NUM_REQ-1.
  function automatic logic [1:0] wrap_idx(input int v);
    if (v >= NUM_REQ) begin
      return 2'(v - NUM_REQ);
    end
    return 2'(v);
  endfunction

  // Requester that follows r in round-robin order.
  function automatic logic [1:0] next_req(input logic [1:0] r);
    return wrap_idx(int'(r) + 1);
  endfunction

endpackage

// File: rtl/storage_arbiter_rd_tag_pipe.sv
// RD_LAT-deep {valid, id} shift register that tags read returns with the
// requester that issued them; clears asynchronously so in-flight reads vanish.
module rd_tag_pipe #(
  parameter int RD_LAT = 1,
  parameter int ID_W   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [ID_W-1:0] i_id,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id
);

  logic [RD_LAT-1:0] r_valid;
  logic [ID_W-1:0]   r_id [RD_LAT];

  // Shift the tag one stage per cycle; stage RD_LAT-1 lines up with RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_id[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_id[0]    <= i_id;
      for (int i = 1; i < RD_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_id[i]    <= r_id[i-1];
      end
    end
  end

  assign o_valid = r_valid[RD_LAT-1];
  assign o_id    = r_id[RD_LAT-1];

endmodule

// File: rtl/storage_arbiter.sv
// Round-robin arbiter for the shared single-port matrix storage RAM with an
// ownership lock for bursts, a lock watchdog and tagged read-data return.
//
// Handshake: request r is accepted on a rising edge where i_req_valid[r] and
// o_req_ready[r] are both high. o_req_ready is one-hot, combinational from the
// current valids and registered state, and a requester keeps
// valid/we/lock/addr/wdata stable until accepted.
module storage_arbiter
  import storage_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            i_req_valid,
  input  logic [2:0]            i_req_we,
  input  logic [2:0]            i_req_lock,
  input  logic [3*ADDR_W-1:0]   i_req_addr,
  input  logic [3*DATA_W-1:0]   i_req_wdata,
  output logic [2:0]            o_req_ready,
  output logic [2:0]            o_rd_valid,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic [1:0]            o_owner,
  output logic                  o_lock_err
);

  localparam int WD_W = $clog2(LOCK_MAX) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LOCK_MAX - 1);

  arb_state_t        r_state;
  logic [1:0]        r_owner;
  logic [1:0]        r_rr_ptr;
  logic [WD_W-1:0]   r_wd;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_last_wdata;

  logic [2:0]        w_grant;
  logic              w_found;
  logic [1:0]        w_scan;
  logic [1:0]        w_gnt_idx;
  logic              w_gnt_any;
  logic              w_gnt_we;
  logic              w_gnt_lock;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_wdata;
  logic              w_release;
  logic              w_wd_expire;
  logic              w_tag_valid;
  logic [1:0]        w_tag_id;

  // Grant: first valid at or after rr_ptr in ARB; only the owner in LOCKED.
  // Nothing is granted while reset is asserted.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_scan  = '0;
    if (rst_n) begin
      if (r_state == ST_ARB) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          w_scan = wrap_idx(int'(r_rr_ptr) + k);
          if (!w_found && i_req_valid[w_scan]) begin
            w_grant[w_scan] = 1'b1;
            w_found         = 1'b1;
          end
        end
      end else if (i_req_valid[r_owner]) begin
        w_grant[r_owner] = 1'b1;
      end
    end
  end

  // Encode the one-hot grant into an index for slicing and tagging.
  always_comb begin
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_gnt_idx = 2'(k);
      end
    end
  end

  assign w_gnt_any   = |w_grant;
  assign w_gnt_we    = w_gnt_any & i_req_we[w_gnt_idx];
  assign w_gnt_lock  = w_gnt_any & i_req_lock[w_gnt_idx];
  assign w_gnt_addr  = i_req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
  assign w_gnt_wdata = i_req_wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];

  // An owner access without lock releases; the watchdog only fires when that
  // did not happen in its final cycle, so a simultaneous release is clean.
  assign w_release   = (r_state == ST_LOCKED) & w_gnt_any & ~w_gnt_lock;
  assign w_wd_expire = (r_state == ST_LOCKED) & (r_wd == WD_LAST) & ~w_release;

  // Arbitration FSM: state, owner, round-robin pointer and lock watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_ARB;
      r_owner  <= OWNER_NONE;
      r_rr_ptr <= 2'd0;
      r_wd     <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_gnt_any) begin
            r_rr_ptr <= next_req(w_gnt_idx);
            if (w_gnt_lock) begin
              r_state <= ST_LOCKED;
              r_owner <= w_gnt_idx;
              r_wd    <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (w_release || w_wd_expire) begin
            r_state  <= ST_ARB;
            r_owner  <= OWNER_NONE;
            r_rr_ptr <= next_req(r_owner);
            r_wd     <= '0;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: begin
          r_state <= ST_ARB;
          r_owner <= OWNER_NONE;
        end
      endcase
    end
  end

  // Remember the last granted command so the RAM bus is quiet when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_addr  <= '0;
      r_last_wdata <= '0;
    end else if (w_gnt_any) begin
      r_last_addr  <= w_gnt_addr;
      r_last_wdata <= w_gnt_wdata;
    end
  end

  assign o_req_ready = w_grant;
  assign o_mem_we    = w_gnt_we;
  assign o_mem_addr  = w_gnt_any ? w_gnt_addr : r_last_addr;
  assign o_mem_wdata = w_gnt_any ? w_gnt_wdata : r_last_wdata;
  assign o_owner     = r_owner;
  assign o_lock_err  = w_wd_expire;

  rd_tag_pipe #(
    .RD_LAT (RD_LAT),
    .ID_W   (2)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_gnt_any & ~w_gnt_we),
    .i_id    (w_gnt_idx),
    .o_valid (w_tag_valid),
    .o_id    (w_tag_id)
  );

  assign o_rd_valid = w_tag_valid ? (3'b001 << w_tag_id) : 3'b000;
  assign o_rd_data  = w_tag_valid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_storage_arbiter.sv
// Bench for storage_arbiter: directed lock/watchdog/reset scenarios plus
// random traffic, checked against a cycle-level reference model and a
// read-return scoreboard.
module tb_storage_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 3;
  localparam int LOCK_MAX = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [2:0]          i_req_valid, i_req_we, i_req_lock;
  logic [3*ADDR_W-1:0] i_req_addr;
  logic [3*DATA_W-1:0] i_req_wdata;
  logic [2:0]          o_req_ready, o_rd_valid;
  logic [DATA_W-1:0]   o_rd_data, o_mem_wdata, i_mem_rdata;
  logic                o_mem_we, o_lock_err;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic [1:0]          o_owner;

  storage_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_we(i_req_we), .i_req_lock(i_req_lock),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_req_ready(o_req_ready), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_owner(o_owner), .o_lock_err(o_lock_err)
  );

  // ---------------- RAM model with RD_LAT read latency ----------------
  logic [DATA_W-1:0] ram [256];
  logic [DATA_W-1:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    rpipe[0] <= ram[o_mem_addr];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
  end
  assign i_mem_rdata = rpipe[RD_LAT-1];

  // ---------------- counters / check ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard: {due_cycle, id, data} ----------------
  logic [65:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rd_valid != 3'b000 || (exp_q.size() > 0 && int'(exp_q[0][65:34]) <= cyc)) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 64'(o_rd_valid), 64'(0));
        end else begin
          logic [65:0] e;
          e = exp_q.pop_front();
          check("rd_valid", 64'(o_rd_valid), 64'(3'b001 << e[33:32]));
          check("rd_data", 64'(o_rd_data), 64'(e[31:0]));
          check("rd_time", 64'(cyc), 64'(e[65:34]));
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  bit                p_valid [3];
  logic              p_we [3];
  logic              p_lock [3];
  logic [ADDR_W-1:0] p_addr [3];
  logic [DATA_W-1:0] p_wdata [3];

  task automatic apply_inputs();
    for (int r = 0; r < 3; r++) begin
      i_req_valid[r] = p_valid[r];
      i_req_we[r]    = p_we[r];
      i_req_lock[r]  = p_lock[r];
      i_req_addr[r*ADDR_W +: ADDR_W]  = p_addr[r];
      i_req_wdata[r*DATA_W +: DATA_W] = p_wdata[r];
    end
  endtask

  task automatic set_req(input int r, input logic we, input logic lk,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    p_valid[r] = 1'b1; p_we[r] = we; p_lock[r] = lk; p_addr[r] = a; p_wdata[r] = d;
  endtask

  task automatic refill_read(input int r);
    if (!p_valid[r]) set_req(r, 1'b0, 1'b0, ADDR_W'($urandom_range(0, 31)), '0);
  endtask

  // ---------------- reference model ----------------
  int                m_rr, m_owner, m_wd;
  bit                m_locked;
  logic [ADDR_W-1:0] m_last_addr;
  logic [DATA_W-1:0] m_last_wdata;
  logic [DATA_W-1:0] ref_mem [256];
  logic [2:0]        last_ready;
  logic              last_err;

  task automatic model_reset();
    m_rr = 0; m_owner = 3; m_wd = 0; m_locked = 0;
    m_last_addr = '0; m_last_wdata = '0;
  endtask

  // One clock cycle: predict and check at negedge, advance model at posedge.
  task automatic step();
    int g;
    bit rel, exp_err, g_we, g_lk;
    logic [ADDR_W-1:0] g_a;
    logic [DATA_W-1:0] g_d;
    apply_inputs();
    @(negedge clk);
    g = -1; g_we = 0; g_lk = 0; g_a = m_last_addr; g_d = m_last_wdata;
    if (!m_locked) begin
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && p_valid[(m_rr + k) % 3]) g = (m_rr + k) % 3;
      end
    end else if (p_valid[m_owner]) begin
      g = m_owner;
    end
    if (g >= 0) begin
      g_we = p_we[g]; g_lk = p_lock[g]; g_a = p_addr[g]; g_d = p_wdata[g];
    end
    check("ready", 64'(o_req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
    check("mem_we", 64'(o_mem_we), 64'(g_we));
    check("mem_addr", 64'(o_mem_addr), 64'(g_a));
    check("mem_wdata", 64'(o_mem_wdata), 64'(g_d));
    check("owner", 64'(o_owner), m_locked ? 64'(m_owner) : 64'(3));
    rel     = m_locked && g >= 0 && !g_lk;
    exp_err = m_locked && (m_wd == LOCK_MAX - 1) && !rel;
    check("lock_err", 64'(o_lock_err), 64'(exp_err));
    last_ready = o_req_ready;
    last_err   = o_lock_err;
    if (g >= 0) begin
      if (g_we) ref_mem[g_a] = g_d;
      else exp_q.push_back({32'(cyc + RD_LAT), 2'(g), ref_mem[g_a]});
    end
    @(posedge clk);
    if (!m_locked) begin
      if (g >= 0) begin
        m_rr = (g + 1) % 3;
        m_last_addr = g_a; m_last_wdata = g_d;
        if (g_lk) begin m_locked = 1; m_owner = g; m_wd = 0; end
      end
    end else begin
      if (g >= 0) begin m_last_addr = g_a; m_last_wdata = g_d; end
      if (rel || m_wd == LOCK_MAX - 1) begin
        m_locked = 0; m_rr = (m_owner + 1) % 3; m_owner = 3;
      end else begin
        m_wd++;
      end
    end
    #1;
    if (g >= 0) p_valid[g] = 0;
    apply_inputs();
  endtask

  task automatic wait_accept(input int r, input string name);
    for (int t = 0; t < 20 && p_valid[r]; t++) step();
    check(name, 64'(p_valid[r]), 64'(0));
  endtask

  task automatic check_reset_outs();
    check("rst_ready", 64'(o_req_ready), 64'(0));
    check("rst_mem_we", 64'(o_mem_we), 64'(0));
    check("rst_mem_addr", 64'(o_mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(o_mem_wdata), 64'(0));
    check("rst_rd_valid", 64'(o_rd_valid), 64'(0));
    check("rst_rd_data", 64'(o_rd_data), 64'(0));
    check("rst_owner", 64'(o_owner), 64'(3));
    check("rst_lock_err", 64'(o_lock_err), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int stall_hits, n_wd;
    bit prev_err;
    for (int a = 0; a < 256; a++) begin
      ram[a] = $urandom; ref_mem[a] = ram[a];
    end
    for (int r = 0; r < 3; r++) begin
      p_valid[r] = 0; p_we[r] = 0; p_lock[r] = 0; p_addr[r] = '0; p_wdata[r] = '0;
    end
    apply_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 check_reset_outs();
    @(posedge clk); #1 rst_n = 1'b1;

    // All three stream reads: grants rotate 0,1,2.
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < 3; r++) refill_read(r);
      step();
    end

    // Requester 2 locks with a write, idles, then reads back and releases.
    set_req(2, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    for (int t = 0; t < 20 && p_valid[2]; t++) begin
      refill_read(0); refill_read(1); step();
    end
    check("lock_wr_accept", 64'(p_valid[2]), 64'(0));
    stall_hits = 0;
    for (int i = 0; i < 5; i++) begin
      refill_read(0); refill_read(1); step();
      stall_hits += int'(last_ready[0] | last_ready[1]);
    end
    set_req(2, 1'b0, 1'b0, 8'h10, '0);
    step();
    stall_hits += int'(last_ready[0] | last_ready[1]);
    check("lock_rd_accept", 64'(p_valid[2]), 64'(0));
    check("lock_stall", 64'(stall_hits), 64'(0));
    check("post_release_owner", 64'(o_owner), 64'(3));
    step();
    check("post_release_gnt", 64'(last_ready), 64'(3'b001));

    // Requester 1 locks then goes idle until the watchdog fires.
    set_req(1, 1'b0, 1'b1, 8'h05, '0);
    for (int t = 0; t < 20 && p_valid[1]; t++) begin
      refill_read(0); refill_read(2); step();
    end
    check("wd_lock_accept", 64'(p_valid[1]), 64'(0));
    n_wd = 0; prev_err = 0;
    for (int i = 0; i < LOCK_MAX + 4; i++) begin
      refill_read(0); refill_read(2); step();
      if (prev_err) check("post_wd_gnt", 64'(last_ready), 64'(3'b100));
      prev_err = last_err;
      n_wd += int'(last_err);
    end
    check("wd_pulse_count", 64'(n_wd), 64'(1));

    // Random traffic with occasional locks and idle owners.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 3; r++) begin
        if (!p_valid[r] && $urandom_range(0, 99) < 60)
          set_req(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                  ADDR_W'($urandom_range(0, 15)), $urandom);
      end
      step();
    end

    // Drain, then reset during a lock with two reads in flight.
    for (int r = 0; r < 3; r++) p_valid[r] = 0;
    for (int t = 0; t < 4 * LOCK_MAX && (exp_q.size() > 0 || m_locked); t++) step();
    check("drain_before_reset", 64'(exp_q.size()), 64'(0));
    set_req(0, 1'b0, 1'b1, 8'h01, '0);
    wait_accept(0, "rst_rd1_accept");
    set_req(0, 1'b0, 1'b1, 8'h02, '0);
    wait_accept(0, "rst_rd2_accept");
    check("inflight_reads", 64'(exp_q.size()), 64'(2));
    check("locked_owner", 64'(o_owner), 64'(0));
    for (int r = 0; r < 3; r++) refill_read(r);
    apply_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #2 check_reset_outs();
    @(negedge clk) check_reset_outs();
    @(posedge clk); #1 rst_n = 1'b1;
    step();
    check("first_gnt_after_rst", 64'(last_ready), 64'(3'b001));
    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < 3; r++) refill_read(r);
      step();
    end

    // Final drain.
    for (int r = 0; r < 3; r++) p_valid[r] = 0;
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) step();
    check("final_drain", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
